// File: rtl/bomb_ctrl.sv
// One-bomb-per-player controller: tile-snapped drop, fuse, cross-shaped blast rectangles, cooldown.
// Latency: all outputs registered, one frame after the triggering edge; no backpressure, requests outside IDLE are dropped.
module bomb_ctrl #(
  parameter int TILE         = 32,
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30,
  parameter int COOL_FRAMES  = 15,
  parameter int RANGE        = 1,
  parameter int ARENA_MIN    = 32,
  parameter int ARENA_X_END  = 608,
  parameter int ARENA_Y_END  = 448
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       bomb_drop,
  input  logic [9:0] userX,
  input  logic [9:0] userY,
  output logic [9:0] bombTX,
  output logic [9:0] bombTY,
  output logic       bomb_vis,
  output logic       exploding,
  output logic [9:0] blastHX,
  output logic [9:0] blastHY,
  output logic [9:0] blastHXS,
  output logic [9:0] blastHYS,
  output logic [9:0] blastVX,
  output logic [9:0] blastVY,
  output logic [9:0] blastVXS,
  output logic [9:0] blastVYS
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] BLAST    = 2'd2;
  localparam logic [1:0] COOLDOWN = 2'd3;

  localparam logic [7:0]  FUSE_LAST  = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0]  BLAST_LAST = 8'(BLAST_FRAMES - 1);
  localparam logic [7:0]  COOL_LAST  = 8'(COOL_FRAMES - 1);
  localparam logic [9:0]  SNAP_MASK  = ~10'(TILE - 1);
  localparam logic [9:0]  CX_OFF     = 10'd9;
  localparam logic [9:0]  CY_OFF     = 10'd13;
  localparam logic [10:0] LO_OFF     = 11'(RANGE * TILE);
  localparam logic [10:0] HI_OFF     = 11'((RANGE + 1) * TILE);
  localparam logic [10:0] A_MIN      = 11'(ARENA_MIN);
  localparam logic [10:0] X_END      = 11'(ARENA_X_END);
  localparam logic [10:0] Y_END      = 11'(ARENA_Y_END);
  localparam logic [9:0]  TILE_SZ    = 10'(TILE);

  typedef struct packed {
    logic [9:0] pos;
    logic [9:0] size;
  } span_t;

  logic [1:0] state;
  logic [7:0] counter;
  logic       drop_prev;
  logic       req;
  logic [9:0] cx;
  logic [9:0] cy;
  span_t      h_arm;
  span_t      v_arm;

  // One arm axis: 11-bit math so neither the low clip nor the high sum can wrap.
  function automatic span_t clip_arm(input logic [9:0] c, input logic [10:0] lim);
    logic [10:0] c11;
    logic [10:0] lo;
    logic [10:0] hi;
    span_t       s;
    c11    = {1'b0, c};
    lo     = (c11 >= A_MIN + LO_OFF) ? c11 - LO_OFF : A_MIN;
    hi     = (c11 + HI_OFF > lim) ? lim : c11 + HI_OFF;
    s.pos  = 10'(lo);
    s.size = (hi > lo) ? 10'(hi - lo) : 10'd0;
    return s;
  endfunction

  assign req   = bomb_drop & ~drop_prev;
  assign cx    = userX + CX_OFF;
  assign cy    = userY + CY_OFF;
  assign h_arm = clip_arm(bombTX, X_END);
  assign v_arm = clip_arm(bombTY, Y_END);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= IDLE;
      counter   <= 8'd0;
      drop_prev <= 1'b1;
      bombTX    <= 10'd0;
      bombTY    <= 10'd0;
      bomb_vis  <= 1'b0;
      exploding <= 1'b0;
      blastHX   <= 10'd0;
      blastHY   <= 10'd0;
      blastHXS  <= 10'd0;
      blastHYS  <= 10'd0;
      blastVX   <= 10'd0;
      blastVY   <= 10'd0;
      blastVXS  <= 10'd0;
      blastVYS  <= 10'd0;
    end else begin
      drop_prev <= bomb_drop;
      case (state)
        IDLE: begin
          if (req) begin
            bombTX   <= cx & SNAP_MASK;
            bombTY   <= cy & SNAP_MASK;
            counter  <= 8'd0;
            bomb_vis <= 1'b1;
            state    <= ARMED;
          end
        end
        ARMED: begin
          if (counter == FUSE_LAST) begin
            counter   <= 8'd0;
            exploding <= 1'b1;
            blastHX   <= h_arm.pos;
            blastHXS  <= h_arm.size;
            blastHY   <= bombTY;
            blastHYS  <= TILE_SZ;
            blastVX   <= bombTX;
            blastVXS  <= TILE_SZ;
            blastVY   <= v_arm.pos;
            blastVYS  <= v_arm.size;
            state     <= BLAST;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        BLAST: begin
          if (counter == BLAST_LAST) begin
            // Zero-size rectangles tell the opposing controller there is nothing to hit.
            counter   <= 8'd0;
            exploding <= 1'b0;
            bomb_vis  <= 1'b0;
            blastHX   <= 10'd0;
            blastHY   <= 10'd0;
            blastHXS  <= 10'd0;
            blastHYS  <= 10'd0;
            blastVX   <= 10'd0;
            blastVY   <= 10'd0;
            blastVXS  <= 10'd0;
            blastVYS  <= 10'd0;
            state     <= COOLDOWN;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        COOLDOWN: begin
          if (counter == COOL_LAST) begin
            counter <= 8'd0;
            state   <= IDLE;
          end else begin
            counter <= counter + 8'd1;
          end
        end
        default: begin
          counter <= 8'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_ctrl.sv
// Bench for bomb_ctrl: fixed vector table, hand sequences for timing corners, random run against a timeline model.
module tb_bomb_ctrl;

  localparam int TILE  = 32;
  localparam int FUSE  = 120;
  localparam int BLST  = 30;
  localparam int COOL  = 15;
  localparam int RANGE = 1;
  localparam int AMIN  = 32;
  localparam int XEND  = 608;
  localparam int YEND  = 448;

  logic       frame_clk;
  logic       Reset;
  logic       bomb_drop;
  logic [9:0] userX;
  logic [9:0] userY;
  logic [9:0] bombTX, bombTY;
  logic       bomb_vis, exploding;
  logic [9:0] blastHX, blastHY, blastHXS, blastHYS;
  logic [9:0] blastVX, blastVY, blastVXS, blastVYS;

  int checks = 0;
  int errors = 0;

  bomb_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .bomb_drop(bomb_drop),
    .userX(userX), .userY(userY),
    .bombTX(bombTX), .bombTY(bombTY), .bomb_vis(bomb_vis), .exploding(exploding),
    .blastHX(blastHX), .blastHY(blastHY), .blastHXS(blastHXS), .blastHYS(blastHYS),
    .blastVX(blastVX), .blastVY(blastVY), .blastVXS(blastVXS), .blastVYS(blastVYS)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  typedef struct {
    int ux, uy, tx, ty, hx, hxs, hy, hys, vx, vy, vxs, vys;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset();
    Reset     = 1'b1;
    bomb_drop = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic drop_bomb(input int ux, input int uy);
    userX     = 10'(ux);
    userY     = 10'(uy);
    bomb_drop = 1'b0;
    step();
    bomb_drop = 1'b1;
    step();
    bomb_drop = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bomb_vis"},  int'(bomb_vis),  0);
    check({tag, "_exploding"}, int'(exploding), 0);
    check({tag, "_blastHX"},   int'(blastHX),   0);
    check({tag, "_blastHY"},   int'(blastHY),   0);
    check({tag, "_blastHXS"},  int'(blastHXS),  0);
    check({tag, "_blastHYS"},  int'(blastHYS),  0);
    check({tag, "_blastVX"},   int'(blastVX),   0);
    check({tag, "_blastVY"},   int'(blastVY),   0);
    check({tag, "_blastVXS"},  int'(blastVXS),  0);
    check({tag, "_blastVYS"},  int'(blastVYS),  0);
  endtask

  // Reference geometry straight from the placement and clipping rules.
  function automatic int snap(input int u, input int off);
    return (((u + off) % 1024) / TILE) * TILE;
  endfunction

  function automatic int arm_pos(input int t);
    int lo = t - RANGE * TILE;
    return (lo < AMIN) ? AMIN : lo;
  endfunction

  function automatic int arm_size(input int t, input int lim);
    int lo = arm_pos(t);
    int hi = t + (RANGE + 1) * TILE;
    if (hi > lim) hi = lim;
    return (hi > lo) ? hi - lo : 0;
  endfunction

  // Second drops during ARMED/BLAST, fuse/blast timing, and the cooldown boundary at offset `off`.
  task automatic full_cycle(input int off, input bit expect_acc);
    int expl_cnt = 0;
    do_reset();
    drop_bomb(300, 200);
    userX = 10'd40;
    userY = 10'd40;
    for (int k = 1; k <= 151 + off; k++) begin
      bomb_drop = (k == 50 || k == 130 || k == 151 + off);
      step();
      if (exploding) expl_cnt++;
      if (k == 50 || k == 130) begin
        check("second_drop_tx", int'(bombTX), 288);
        check("second_drop_ty", int'(bombTY), 192);
        check("second_drop_vis", int'(bomb_vis), 1);
      end
      if (k == FUSE - 1) check("fuse_not_yet", int'(exploding), 0);
      if (k == FUSE)     check("fuse_fires", int'(exploding), 1);
      if (k == FUSE + BLST) check_all_zero("blast_exit");
    end
    check("explode_frames", expl_cnt, BLST);
    check($sformatf("cool_drop_%0d_vis", off), int'(bomb_vis), expect_acc ? 1 : 0);
    check($sformatf("cool_drop_%0d_tx", off), int'(bombTX), expect_acc ? 32 : 288);
    bomb_drop = 1'b0;
    step();
    check($sformatf("cool_drop_%0d_vis_after", off), int'(bomb_vis), expect_acc ? 1 : 0);
  endtask

  initial begin
    Reset     = 1'b1;
    bomb_drop = 1'b1;
    userX     = 10'd0;
    userY     = 10'd0;

    vecs[0] = '{34,   34,  32,  32,  32, 64,  32, 32,  32,  32, 32, 64};
    vecs[1] = '{300,  200, 288, 192, 256, 96, 192, 32, 288, 160, 32, 96};
    vecs[2] = '{590,  430, 576, 416, 544, 64, 416, 32, 576, 384, 32, 64};
    vecs[3] = '{0,    0,   0,   0,   32,  32, 0,   32, 0,   32,  32, 32};
    vecs[4] = '{1000, 460, 992, 448, 960, 0,  448, 32, 992, 416, 32, 32};
    vecs[5] = '{55,   51,  64,  64,  32,  96, 64,  32, 64,  32,  32, 96};

    // Reset with the drop key held, then release with it still held.
    repeat (3) step();
    check("reset_tx", int'(bombTX), 0);
    check("reset_ty", int'(bombTY), 0);
    check_all_zero("reset");
    Reset = 1'b0;
    repeat (3) step();
    check("held_drop_vis", int'(bomb_vis), 0);
    bomb_drop = 1'b0;
    step();
    check("held_drop_release_vis", int'(bomb_vis), 0);

    foreach (vecs[i]) begin
      do_reset();
      drop_bomb(vecs[i].ux, vecs[i].uy);
      check($sformatf("v%0d_tx", i), int'(bombTX), vecs[i].tx);
      check($sformatf("v%0d_ty", i), int'(bombTY), vecs[i].ty);
      check($sformatf("v%0d_vis", i), int'(bomb_vis), 1);
      check($sformatf("v%0d_armed_hxs", i), int'(blastHXS), 0);
      repeat (FUSE - 1) step();
      check($sformatf("v%0d_armed_expl", i), int'(exploding), 0);
      step();
      check($sformatf("v%0d_expl", i), int'(exploding), 1);
      check($sformatf("v%0d_hx", i),  int'(blastHX),  vecs[i].hx);
      check($sformatf("v%0d_hxs", i), int'(blastHXS), vecs[i].hxs);
      check($sformatf("v%0d_hy", i),  int'(blastHY),  vecs[i].hy);
      check($sformatf("v%0d_hys", i), int'(blastHYS), vecs[i].hys);
      check($sformatf("v%0d_vx", i),  int'(blastVX),  vecs[i].vx);
      check($sformatf("v%0d_vy", i),  int'(blastVY),  vecs[i].vy);
      check($sformatf("v%0d_vxs", i), int'(blastVXS), vecs[i].vxs);
      check($sformatf("v%0d_vys", i), int'(blastVYS), vecs[i].vys);
    end

    full_cycle(14, 1'b0);
    full_cycle(15, 1'b1);

    // Reset in the middle of the blast.
    do_reset();
    drop_bomb(300, 200);
    repeat (FUSE + 5) step();
    check("midblast_expl_before", int'(exploding), 1);
    Reset = 1'b1;
    step();
    check_all_zero("midblast_reset");
    check("midblast_reset_tx", int'(bombTX), 0);
    Reset = 1'b0;
    repeat (3) step();
    check("midblast_after_vis", int'(bomb_vis), 0);

    // Random drops and positions against a timeline model of the bomb life cycle.
    begin
      int  e = 0, n_acc = 0, k, tx = 0, ty = 0;
      bit  have = 1'b0, dprev = 1'b1, d = 1'b0, rise, idle_before, vis, ex;
      logic [101:0] act, exp;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 5) == 0) d = ~d;
        bomb_drop = d;
        userX = 10'($urandom_range(0, 1023));
        userY = 10'($urandom_range(0, 1023));
        step();
        e++;
        rise  = d && !dprev;
        dprev = d;
        idle_before = !have || (e - 1 - n_acc) >= FUSE + BLST + COOL;
        if (rise && idle_before) begin
          have  = 1'b1;
          n_acc = e;
          tx    = snap(int'(userX), 9);
          ty    = snap(int'(userY), 13);
        end
        k   = e - n_acc;
        vis = have && k < FUSE + BLST;
        ex  = have && k >= FUSE && k < FUSE + BLST;
        exp = {10'(tx), 10'(ty),
               ex ? 10'(arm_pos(tx)) : 10'd0, ex ? 10'(arm_size(tx, XEND)) : 10'd0,
               ex ? 10'(ty) : 10'd0, ex ? 10'(TILE) : 10'd0,
               ex ? 10'(tx) : 10'd0, ex ? 10'(arm_pos(ty)) : 10'd0,
               ex ? 10'(TILE) : 10'd0, ex ? 10'(arm_size(ty, YEND)) : 10'd0,
               vis, ex};
        act = {bombTX, bombTY, blastHX, blastHXS, blastHY, blastHYS,
               blastVX, blastVY, blastVXS, blastVYS, bomb_vis, exploding};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL rand_cycle_%0d: got %h expected %h", c, act, exp);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
